dmem_bus_bridge: RTL
====================

Name: dmem_bus_bridge

Overview:
- Data-side load/store bridge directly downstream of the single-cycle core's memory port (address, rs2_data, mem_read, mem_write, fn3).
- Converts the core's combinational access into a req/ack bus transaction with byte enables; stalls the core until the transaction completes.
- Returns sign- or zero-extended load data on rd_data, which the core consumes as its memory output.
- Flags misaligned/illegal accesses and bus timeouts.

Parameters:
- N, 32, data/address width (fixed at 32 for RV32).
- TIMEOUT_CYCLES, 16, maximum REQ-state cycles before abort (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  32  core byte address (ALU result).
- wr_data  input  32  core store data (rs2_data).
- mem_read  input  1  core load request.
- mem_write  input  1  core store request.
- fn3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_data  output  32  extended load data to core.
- stall  output  1  core must hold PC/regfile write while high.
- access_err  output  1  one-cycle pulse: misaligned or illegal fn3.
- bus_err  output  1  one-cycle pulse: timeout abort.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address ({address[31:2],2'b00}).
- bus_be  output  4  byte lane enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  bus completion, sampled in REQ.
- bus_rdata  input  32  read data, valid with bus_ack.

Behaviour:
- Reset: state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rd_data=0, access_err=0, bus_err=0, stall=0, timeout counter=0.
- States: IDLE, REQ, DONE.
- acc = mem_read|mem_write. If both are high, the access is treated as a read.
- bad = acc & (illegal fn3 | H/HU with address[0]=1 | W with address[1:0]!=0). Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
- IDLE:
  - stall = acc & ~bad (combinational).
  - If acc & ~bad: latch bus_addr, bus_we, bus_be, bus_wdata, fn3 and address[1:0]; go to REQ.
  - If acc & bad: access_err=1 next cycle; no bus transaction; rd_data=0; remain IDLE; no stall.
- REQ:
  - bus_req=1, stall=1.
  - On bus_ack=1: capture and extend bus_rdata into rd_data (writes: rd_data=0); go to DONE.
  - Bus outputs stay stable until ack.
- DONE:
  - stall=0, bus_req=0, rd_data valid; the core advances at this edge.
  - Always returns to IDLE, never re-triggers on the still-asserted request.
- Latency: zero-wait ack gives 3 cycles per access (request, REQ+ack, DONE). Each wait cycle adds 1.
- Byte enables:
  - B: 4'b0001<<address[1:0].
  - H: address[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
- Store data: B replicates wr_data[7:0] ×4; H replicates wr_data[15:0] ×2; W passes wr_data through.
- Load extraction uses the latched offset. B/H are sign-extended, BU/HU zero-extended.
- rd_data holds its value until the next capture or access_err.
- Reset asserted in any state returns to IDLE at that edge. An in-flight request is dropped (bus_req=0 next cycle), and a late ack is ignored.
- bus_ack outside REQ is ignored.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - The counter increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES: go to DONE, rd_data=0, bus_err pulses 1 cycle, bus_req drops.
  - The counter clears on leaving REQ.
- Undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Test Plan:
- LW addr 0x100, ack on first REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, stall high 2 cycles, rd_data=0xDEADBEEF in DONE.
- LB addr 0x103, bus_rdata=0x80112233 -> bus_be=1000, rd_data=0xFFFFFF80. LBU same access -> rd_data=0x00000080.
- SH addr 0x202, wr_data=0x0000ABCD, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, stall high 5 cycles.
- LW addr 0x101 -> no bus_req, access_err pulse, stall=0, rd_data=0. fn3=011 load -> same response.
- Reset asserted during REQ, then ack one cycle later -> IDLE, bus_req=0, ack ignored, rd_data=0.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles: bus_err pulse, DONE, rd_data=0, stall released.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// Data-side load/store bridge: turns the core's combinational memory access into a
// req/ack bus transaction and stalls the core. Optional bus timeout under DMEM_TIMEOUT_EN.
module dmem_bus_bridge #(
    parameter int unsigned N              = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] address,
    input  logic [N-1:0] wr_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   fn3,
    output logic [N-1:0] rd_data,
    output logic         stall,
    output logic         access_err,
    output logic         bus_err,
    output logic         bus_req,
    output logic         bus_we,
    output logic [N-1:0] bus_addr,
    output logic [3:0]   bus_be,
    output logic [N-1:0] bus_wdata,
    input  logic         bus_ack,
    input  logic [N-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  fn3_q;
    logic [1:0]  off_q;

    logic        acc;
    logic        is_store;
    logic        fn3_ok;
    logic        align_ok;
    logic        bad;
    logic [3:0]  be_c;
    logic [N-1:0] wdata_c;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign bus_err    = 1'b0;
`endif

    // Access decode: legality, alignment, lane enables and replicated store data
    always_comb begin
        acc      = mem_read | mem_write;
        is_store = mem_write & ~mem_read;
        fn3_ok   = 1'b0;
        align_ok = 1'b1;
        be_c     = 4'b1111;
        wdata_c  = wr_data;

        case (fn3)
            3'b000, 3'b001, 3'b010: fn3_ok = 1'b1;
            3'b100, 3'b101:         fn3_ok = ~is_store;
            default:                fn3_ok = 1'b0;
        endcase

        case (fn3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << address[1:0];
                wdata_c = {4{wr_data[7:0]}};
            end
            2'b01: begin
                align_ok = ~address[0];
                be_c     = address[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {2{wr_data[15:0]}};
            end
            2'b10: begin
                align_ok = (address[1:0] == 2'b00);
            end
            default: begin
                align_ok = 1'b1;
            end
        endcase

        bad = acc & (~fn3_ok | ~align_ok);
    end

    // Core is held during the request cycle and every REQ cycle; released in DONE
    assign stall = (state == REQ) | ((state == IDLE) & acc & ~bad);

    // Pick the addressed byte/half from the returned word and extend it
    function automatic logic [N-1:0] load_ext(input logic [2:0] f,
                                              input logic [1:0] off,
                                              input logic [N-1:0] data);
        logic [N-1:0] sh;
        sh = data >> {off, 3'b000};
        case (f)
            3'b000:  load_ext = {{(N-8){sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{(N-16){sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {{(N-8){1'b0}}, sh[7:0]};
            3'b101:  load_ext = {{(N-16){1'b0}}, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fn3_q      <= 3'b000;
            off_q      <= 2'b00;
            rd_data    <= '0;
            access_err <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= '0;
`ifdef DMEM_TIMEOUT_EN
            bus_err    <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            access_err <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_err    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (acc && !bad) begin
                        bus_addr  <= {address[N-1:2], 2'b00};
                        bus_we    <= is_store;
                        bus_be    <= be_c;
                        bus_wdata <= wdata_c;
                        fn3_q     <= fn3;
                        off_q     <= address[1:0];
                        bus_req   <= 1'b1;
                        state     <= REQ;
                    end else if (acc) begin
                        access_err <= 1'b1;
                        rd_data    <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        rd_data <= bus_we ? '0 : load_ext(fn3_q, off_q, bus_rdata);
                        bus_req <= 1'b0;
                        state   <= DONE;
`ifdef DMEM_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rd_data <= '0;
                        bus_err <= 1'b1;
                        bus_req <= 1'b0;
                        to_cnt  <= '0;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                // Core advances here; the still-asserted request is not re-issued
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
